// File: rtl/trap_sequencer.sv
// Machine-mode trap entry / MRET sequencer that owns the CSR write port while a trap is in flight.
// Optional mtval write enabled by defining TRAP_SEQ_MTVAL_EN.
module trap_sequencer #(
    parameter logic [11:0] MEPC_ADDR   = 12'h341,
    parameter logic [11:0] MCAUSE_ADDR = 12'h342,
    parameter logic [11:0] MTVAL_ADDR  = 12'h343
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        XB_exc_illegal_instruction,
    input  logic        FD_exc_illegal_instruction,
    input  logic        FD_exc_instruction_misaligned,
    input  logic        FD_exc_memory_misaligned,
    input  logic        FD_exc_is_store,
    input  logic [31:0] FD_pc,
    input  logic [31:0] XB_pc,
    input  logic [31:0] FD_bad_addr,
    input  logic [31:0] FD_instr,
    input  logic        mret,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc_in,
    input  logic        ins_csr_we,
    input  logic [11:0] ins_csr_addr,
    input  logic [31:0] ins_csr_wdata,
    output logic        ins_csr_stall,
    output logic        csr_we,
    output logic [11:0] csr_addr,
    output logic [31:0] csr_wdata,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        busy
);

`ifdef TRAP_SEQ_MTVAL_EN
    typedef enum logic [2:0] {
        IDLE, WR_MEPC, WR_MCAUSE, WR_MTVAL, TRAP_REDIR, MRET_REDIR
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, WR_MEPC, WR_MCAUSE, TRAP_REDIR, MRET_REDIR
    } state_t;
`endif

    state_t      state, state_nxt;
    logic [31:0] pc_q;
    logic [3:0]  cause_q;
    logic        exc_any;
    logic [31:0] sel_pc;
    logic [3:0]  sel_cause;
`ifdef TRAP_SEQ_MTVAL_EN
    logic [31:0] tval_q;
    logic [31:0] sel_tval;
`endif

    assign exc_any = XB_exc_illegal_instruction | FD_exc_illegal_instruction |
                     FD_exc_instruction_misaligned | FD_exc_memory_misaligned;

    // Priority select of the trapping instruction's pc/cause/tval; XB is older than FD.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        sel_pc    = FD_pc;
        sel_cause = 4'd0;
`ifdef TRAP_SEQ_MTVAL_EN
        sel_tval  = FD_bad_addr;
`endif
        if (XB_exc_illegal_instruction) begin
            sel_pc    = XB_pc;
            sel_cause = 4'd2;
`ifdef TRAP_SEQ_MTVAL_EN
            sel_tval  = 32'd0;
`endif
        end else if (FD_exc_illegal_instruction) begin
            sel_cause = 4'd2;
`ifdef TRAP_SEQ_MTVAL_EN
            sel_tval  = FD_instr;
`endif
        end else if (FD_exc_instruction_misaligned) begin
            sel_cause = 4'd0;
        end else if (FD_exc_memory_misaligned) begin
            sel_cause = FD_exc_is_store ? 4'd6 : 4'd4;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            pc_q    <= 32'd0;
            cause_q <= 4'd0;
`ifdef TRAP_SEQ_MTVAL_EN
            tval_q  <= 32'd0;
`endif
        end else begin
            state <= state_nxt;
            if (state == IDLE && exc_any) begin
                pc_q    <= sel_pc;
                cause_q <= sel_cause;
`ifdef TRAP_SEQ_MTVAL_EN
                tval_q  <= sel_tval;
`endif
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        ins_csr_stall  = 1'b1;
        csr_we         = 1'b0;
        csr_addr       = 12'd0;
        csr_wdata      = 32'd0;
        flush          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        busy           = 1'b1;
        unique case (state)
            IDLE: begin
                ins_csr_stall = 1'b0;
                flush         = 1'b0;
                busy          = 1'b0;
                // A write from the faulting instruction must not commit.
                csr_we        = ins_csr_we & ~exc_any;
                csr_addr      = ins_csr_addr;
                csr_wdata     = ins_csr_wdata;
                if (exc_any)   state_nxt = WR_MEPC;
                else if (mret) state_nxt = MRET_REDIR;
            end
            WR_MEPC: begin
                csr_we    = 1'b1;
                csr_addr  = MEPC_ADDR;
                csr_wdata = {pc_q[31:2], 2'b00};
                state_nxt = WR_MCAUSE;
            end
            WR_MCAUSE: begin
                csr_we    = 1'b1;
                csr_addr  = MCAUSE_ADDR;
                csr_wdata = {1'b0, 27'd0, cause_q};
`ifdef TRAP_SEQ_MTVAL_EN
                state_nxt = WR_MTVAL;
`else
                state_nxt = TRAP_REDIR;
`endif
            end
`ifdef TRAP_SEQ_MTVAL_EN
            WR_MTVAL: begin
                csr_we    = 1'b1;
                csr_addr  = MTVAL_ADDR;
                csr_wdata = tval_q;
                state_nxt = TRAP_REDIR;
            end
`endif
            TRAP_REDIR: begin
                redirect_valid = 1'b1;
                redirect_pc    = {mtvec[31:2], 2'b00};
                state_nxt      = IDLE;
            end
            MRET_REDIR: begin
                redirect_valid = 1'b1;
                redirect_pc    = {mepc_in[31:2], 2'b00};
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Synchronous reset also silences the outputs in the cycle it is asserted.
        if (reset) begin
            ins_csr_stall  = 1'b0;
            csr_we         = 1'b0;
            flush          = 1'b0;
            redirect_valid = 1'b0;
            redirect_pc    = 32'd0;
            busy           = 1'b0;
        end
    end

endmodule

// File: tb/tb_trap_sequencer.sv
// Scoreboard bench for trap_sequencer: expected CSR writes and redirects are queued at stimulus time
// and popped by a monitor on the falling edge; builds with or without TRAP_SEQ_MTVAL_EN.
module tb_trap_sequencer;

`ifdef TRAP_SEQ_MTVAL_EN
    localparam bit MTVAL_ON = 1'b1;
`else
    localparam bit MTVAL_ON = 1'b0;
`endif

    typedef struct packed {
        logic [11:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        XB_exc_illegal_instruction = 1'b0;
    logic        FD_exc_illegal_instruction = 1'b0;
    logic        FD_exc_instruction_misaligned = 1'b0;
    logic        FD_exc_memory_misaligned = 1'b0;
    logic        FD_exc_is_store = 1'b0;
    logic [31:0] FD_pc = '0, XB_pc = '0, FD_bad_addr = '0, FD_instr = '0;
    logic        mret = 1'b0;
    logic [31:0] mtvec = '0, mepc_in = '0;
    logic        ins_csr_we = 1'b0;
    logic [11:0] ins_csr_addr = '0;
    logic [31:0] ins_csr_wdata = '0;
    logic        ins_csr_stall, csr_we, flush, redirect_valid, busy;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata, redirect_pc;

    int n_checks = 0;
    int n_errors = 0;
    wr_t         exp_wr[$];
    logic [31:0] exp_redir[$];

    trap_sequencer dut (
        .clk(clk), .reset(reset),
        .XB_exc_illegal_instruction(XB_exc_illegal_instruction),
        .FD_exc_illegal_instruction(FD_exc_illegal_instruction),
        .FD_exc_instruction_misaligned(FD_exc_instruction_misaligned),
        .FD_exc_memory_misaligned(FD_exc_memory_misaligned),
        .FD_exc_is_store(FD_exc_is_store),
        .FD_pc(FD_pc), .XB_pc(XB_pc), .FD_bad_addr(FD_bad_addr), .FD_instr(FD_instr),
        .mret(mret), .mtvec(mtvec), .mepc_in(mepc_in),
        .ins_csr_we(ins_csr_we), .ins_csr_addr(ins_csr_addr), .ins_csr_wdata(ins_csr_wdata),
        .ins_csr_stall(ins_csr_stall), .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
        .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy)
    );

    always #5 clk = ~clk;

    // Monitor: every CSR write and redirect must match the head of its queue.
    always @(negedge clk) begin
        if (csr_we === 1'b1) begin
            n_checks++;
            if (exp_wr.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_write: got addr=%h data=%h, none expected", csr_addr, csr_wdata);
            end else begin
                wr_t e;
                e = exp_wr.pop_front();
                if (csr_addr !== e.addr || csr_wdata !== e.data) begin
                    n_errors++;
                    $display("FAIL csr_write: got addr=%h data=%h, expected addr=%h data=%h",
                             csr_addr, csr_wdata, e.addr, e.data);
                end
            end
        end
        if (redirect_valid === 1'b1) begin
            n_checks++;
            if (exp_redir.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_redirect: got pc=%h, none expected", redirect_pc);
            end else begin
                logic [31:0] r;
                r = exp_redir.pop_front();
                if (redirect_pc !== r) begin
                    n_errors++;
                    $display("FAIL redirect_pc: got %h, expected %h", redirect_pc, r);
                end
            end
        end else if (!reset) begin
            n_checks++;
            if (redirect_pc !== 32'd0) begin
                n_errors++;
                $display("FAIL redirect_pc_idle: got %h, expected 00000000", redirect_pc);
            end
        end
    end

    task automatic clear_exc();
        XB_exc_illegal_instruction = 1'b0;
        FD_exc_illegal_instruction = 1'b0;
        FD_exc_instruction_misaligned = 1'b0;
        FD_exc_memory_misaligned = 1'b0;
        FD_exc_is_store = 1'b0;
        mret = 1'b0;
    endtask

    // Runs a full trap after the exception flags have been driven; checks per-cycle status.
    task automatic run_trap(input string name, input logic [31:0] exp_pc, input logic [3:0] exp_cause,
                            input logic [31:0] exp_tval, input logic [31:0] exp_vec);
        int len;
        len = MTVAL_ON ? 4 : 3;
        exp_wr.push_back('{addr: 12'h341, data: exp_pc});
        exp_wr.push_back('{addr: 12'h342, data: {28'd0, exp_cause}});
        if (MTVAL_ON) exp_wr.push_back('{addr: 12'h343, data: exp_tval});
        exp_redir.push_back(exp_vec);
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || flush !== 1'b0 || csr_we !== 1'b0) begin
            n_errors++;
            $display("FAIL %s_capture: busy=%b flush=%b csr_we=%b, expected 0 0 0", name, busy, flush, csr_we);
        end
        @(posedge clk); #1;
        clear_exc();
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            n_checks++;
            if (busy !== 1'b1 || flush !== 1'b1 || ins_csr_stall !== 1'b1 ||
                redirect_valid !== (k == len)) begin
                n_errors++;
                $display("FAIL %s_cycle%0d: busy=%b flush=%b stall=%b rv=%b, expected 1 1 1 %b",
                         name, k, busy, flush, ins_csr_stall, redirect_valid, k == len);
            end
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || flush !== 1'b0) begin
            n_errors++;
            $display("FAIL %s_return_idle: busy=%b flush=%b, expected 0 0", name, busy, flush);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        FD_exc_illegal_instruction = 1'b1;
        ins_csr_we = 1'b1;
        ins_csr_addr = 12'h340;
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || flush !== 1'b0 || redirect_valid !== 1'b0 ||
            csr_we !== 1'b0 || ins_csr_stall !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_outputs: busy=%b flush=%b rv=%b we=%b stall=%b, expected all 0",
                     busy, flush, redirect_valid, csr_we, ins_csr_stall);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        clear_exc();
        ins_csr_we = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || flush !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_idle: busy=%b flush=%b, expected 0 0", busy, flush);
        end
    endtask

    task automatic test_fd_illegal();
        @(posedge clk); #1;
        FD_exc_illegal_instruction = 1'b1;
        FD_pc = 32'h100; FD_instr = 32'hFFFF_FFFF; mtvec = 32'h203;
        // Faulting instruction's own CSR write must be dropped.
        ins_csr_we = 1'b1; ins_csr_addr = 12'h340; ins_csr_wdata = 32'hDEAD;
        run_trap("fd_illegal", 32'h100, 4'd2, 32'hFFFF_FFFF, 32'h200);
        ins_csr_we = 1'b0;
    endtask

    task automatic test_priority();
        @(posedge clk); #1;
        XB_exc_illegal_instruction = 1'b1; XB_pc = 32'h43;
        FD_exc_memory_misaligned = 1'b1; FD_exc_is_store = 1'b1;
        FD_pc = 32'h500; FD_bad_addr = 32'h777; mtvec = 32'h80;
        run_trap("priority", 32'h40, 4'd2, 32'h0, 32'h80);
    endtask

    task automatic test_misaligned();
        @(posedge clk); #1;
        FD_exc_memory_misaligned = 1'b1; FD_exc_is_store = 1'b0;
        FD_pc = 32'h600; FD_bad_addr = 32'h602; mtvec = 32'h1000;
        run_trap("load_misaligned", 32'h600, 4'd4, 32'h602, 32'h1000);
        @(posedge clk); #1;
        FD_exc_memory_misaligned = 1'b1; FD_exc_is_store = 1'b1;
        FD_pc = 32'h704; FD_bad_addr = 32'h705;
        run_trap("store_misaligned", 32'h704, 4'd6, 32'h705, 32'h1000);
        @(posedge clk); #1;
        FD_exc_instruction_misaligned = 1'b1; FD_exc_memory_misaligned = 1'b1;
        FD_pc = 32'h808; FD_bad_addr = 32'h80A;
        run_trap("instr_misaligned", 32'h808, 4'd0, 32'h80A, 32'h1000);
    endtask

    task automatic test_mret();
        @(posedge clk); #1;
        mret = 1'b1; mepc_in = 32'h1237;
        exp_redir.push_back(32'h1234);
        @(posedge clk); #1;
        clear_exc();
        @(negedge clk);
        n_checks++;
        if (redirect_valid !== 1'b1 || csr_we !== 1'b0 || busy !== 1'b1 || flush !== 1'b1) begin
            n_errors++;
            $display("FAIL mret_redirect: rv=%b we=%b busy=%b flush=%b, expected 1 0 1 1",
                     redirect_valid, csr_we, busy, flush);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || redirect_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL mret_idle: busy=%b rv=%b, expected 0 0", busy, redirect_valid);
        end
    endtask

    task automatic test_passthrough();
        @(posedge clk); #1;
        ins_csr_we = 1'b1; ins_csr_addr = 12'h340; ins_csr_wdata = 32'hABCD;
        exp_wr.push_back('{addr: 12'h340, data: 32'hABCD});
        @(negedge clk);
        n_checks++;
        if (csr_we !== 1'b1 || ins_csr_stall !== 1'b0) begin
            n_errors++;
            $display("FAIL passthrough: we=%b stall=%b, expected 1 0", csr_we, ins_csr_stall);
        end
        @(posedge clk); #1;
        ins_csr_we = 1'b0;
    endtask

    task automatic test_stall();
        int len;
        len = MTVAL_ON ? 4 : 3;
        @(posedge clk); #1;
        FD_exc_instruction_misaligned = 1'b1; FD_pc = 32'h204; FD_bad_addr = 32'h206; mtvec = 32'h3000;
        exp_wr.push_back('{addr: 12'h341, data: 32'h204});
        exp_wr.push_back('{addr: 12'h342, data: 32'h0});
        if (MTVAL_ON) exp_wr.push_back('{addr: 12'h343, data: 32'h206});
        exp_redir.push_back(32'h3000);
        @(posedge clk); #1;
        clear_exc();
        ins_csr_we = 1'b1; ins_csr_addr = 12'h340; ins_csr_wdata = 32'h55;
        exp_wr.push_back('{addr: 12'h340, data: 32'h55});
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (ins_csr_stall !== 1'b1 || csr_addr !== 12'h342) begin
            n_errors++;
            $display("FAIL stall_mcause: stall=%b addr=%h, expected 1 342", ins_csr_stall, csr_addr);
        end
        repeat (len - 1) @(negedge clk);
        n_checks++;
        if (csr_we !== 1'b1 || csr_addr !== 12'h340 || ins_csr_stall !== 1'b0) begin
            n_errors++;
            $display("FAIL stall_release: we=%b addr=%h stall=%b, expected 1 340 0",
                     csr_we, csr_addr, ins_csr_stall);
        end
        @(posedge clk); #1;
        ins_csr_we = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        FD_exc_memory_misaligned = 1'b1; FD_pc = 32'h300; FD_bad_addr = 32'h301;
        exp_wr.push_back('{addr: 12'h341, data: 32'h300});
        @(posedge clk); #1;
        clear_exc();
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (csr_we !== 1'b0 || flush !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mid: we=%b flush=%b busy=%b, expected 0 0 0", csr_we, flush, busy);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++;
            if (busy !== 1'b0 || flush !== 1'b0 || redirect_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_mid_after%0d: busy=%b flush=%b rv=%b, expected 0 0 0",
                         k, busy, flush, redirect_valid);
            end
        end
    endtask

    task automatic test_drain();
        int budget;
        budget = 20;
        while ((exp_wr.size() != 0 || exp_redir.size() != 0) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        n_checks++;
        if (exp_wr.size() != 0 || exp_redir.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d writes and %0d redirects still pending, expected 0 0",
                     exp_wr.size(), exp_redir.size());
        end
    endtask

    initial begin
        test_reset();
        test_fd_illegal();
        test_priority();
        test_misaligned();
        test_mret();
        test_passthrough();
        test_stall();
        test_reset_mid();
        test_drain();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
